// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared FSM encoding, colours and screen limits for draw_engine
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [2:0] COLOUR_ERASE = 3'b011;
  localparam logic [2:0] COLOUR_BIRD  = 3'b110;
  localparam logic [2:0] COLOUR_WALL  = 3'b010;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // True when v lies in the half-open span [lo, lo+len); 9 bits keep lo+len from wrapping
  function automatic logic in_span(input logic [8:0] v, input logic [8:0] lo,
                                   input logic [8:0] len);
    in_span = (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/draw_if.sv
// rtl/draw_if.sv - request, status and VGA pixel port bundle of draw_engine
interface draw_if;

  logic       start;
  logic       obj_sel;
  logic       erase;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic [6:0] gap_y;
  logic       busy;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       touched;

  modport master (
    output start, obj_sel, erase, obj_x, obj_y, gap_y,
    input  busy, done, vga_x, vga_y, vga_colour, vga_plot, touched
  );

  modport slave (
    input  start, obj_sel, erase, obj_x, obj_y, gap_y,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot, touched
  );

endinterface

// File: rtl/rect_scan.sv
// rtl/rect_scan.sv - row-major column/row counter with last-pixel flag
module rect_scan (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [7:0] width_i,
  input  logic [6:0] height_i,
  output logic [7:0] col_o,
  output logic [6:0] row_o,
  output logic       last_o
);

  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic       col_wrap;

  assign col_wrap = (col_q == width_i - 8'd1);

  // Advance one pixel per enabled cycle, wrapping the column into the next row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_wrap && (row_q == height_i - 7'd1);

endmodule

// File: rtl/draw_engine.sv
// rtl/draw_engine.sv - bird/wall rectangle painter for the VGA adapter; DRAW_COLLIDE_EN adds the overlap flag
module draw_engine
  import draw_pkg::*;
#(
  parameter int BIRD_W = 4,
  parameter int BIRD_H = 4,
  parameter int WALL_W = 8,
  parameter int GAP_H  = 32
) (
  input logic   clk,
  input logic   resetn,
  draw_if.slave bus
);

  state_e     state_q, state_d;
  logic       sel_q;
  logic       erase_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [6:0] gap_q;

  logic [7:0] bird_x_q;
  logic [6:0] bird_y_q;
  logic       bird_valid_q;

  logic       accept;
  logic       scan_clear;
  logic       scan_en;
  logic [7:0] scan_w;
  logic [6:0] scan_h;
  logic [7:0] col;
  logic [6:0] row;
  logic       last;

  logic [8:0] x_full;
  logic [6:0] y_base;
  logic [7:0] y_full;
  logic       drawing;
  logic       on_screen;
  logic       in_gap;
  logic       plot;
  logic [2:0] colour;

  assign accept = (state_q == ST_IDLE) && bus.start;

  // Capture the request parameters; starts outside IDLE never reach here
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q   <= 1'b0;
      erase_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      gap_q   <= '0;
    end else if (accept) begin
      sel_q   <= bus.obj_sel;
      erase_q <= bus.erase;
      x_q     <= bus.obj_x;
      y_q     <= bus.obj_y;
      gap_q   <= bus.gap_y;
    end
  end

  // Remember where the bird was last painted so walls can test against it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bird_x_q     <= '0;
      bird_y_q     <= '0;
      bird_valid_q <= 1'b0;
    end else if (accept && bus.obj_sel && !bus.erase) begin
      bird_x_q     <= bus.obj_x;
      bird_y_q     <= bus.obj_y;
      bird_valid_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state and counter control
  always_comb begin
    state_d    = state_q;
    scan_clear = 1'b0;
    scan_en    = 1'b0;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_LOAD;
      ST_LOAD: begin
        scan_clear = 1'b1;
        state_d    = ST_DRAW;
      end
      ST_DRAW: begin
        scan_en = 1'b1;
        if (last) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign scan_w = sel_q ? 8'(BIRD_W) : 8'(WALL_W);
  assign scan_h = sel_q ? 7'(BIRD_H) : 7'(SCREEN_H);

  rect_scan u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .clear_i  (scan_clear),
    .en_i     (scan_en),
    .width_i  (scan_w),
    .height_i (scan_h),
    .col_o    (col),
    .row_o    (row),
    .last_o   (last)
  );

  // Untruncated coordinates decide clipping; the ports only carry the low bits
  assign x_full    = {1'b0, x_q} + {1'b0, col};
  assign y_base    = sel_q ? y_q : 7'd0;
  assign y_full    = {1'b0, y_base} + {1'b0, row};
  assign drawing   = (state_q == ST_DRAW);
  assign on_screen = (x_full < 9'(SCREEN_W)) && (y_full < 8'(SCREEN_H));
  assign in_gap    = !sel_q && in_span({2'b00, row}, {2'b00, gap_q}, 9'(GAP_H));
  assign plot      = drawing && on_screen && !in_gap;
  assign colour    = erase_q ? COLOUR_ERASE : (sel_q ? COLOUR_BIRD : COLOUR_WALL);

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_FINISH);
  assign bus.vga_plot   = plot;
  assign bus.vga_x      = drawing ? x_full[7:0] : 8'd0;
  assign bus.vga_y      = drawing ? y_full[6:0] : 7'd0;
  assign bus.vga_colour = drawing ? colour : 3'd0;

`ifdef DRAW_COLLIDE_EN
  logic touched_q, touched_d;
  logic hit;

  assign hit = bird_valid_q
            && in_span(x_full, {1'b0, bird_x_q}, 9'(BIRD_W))
            && in_span({1'b0, y_full}, {2'b00, bird_y_q}, 9'(BIRD_H));

  // Sticky overlap flag: a painted wall pixel landing on the bird box
  always_comb begin
    touched_d = touched_q;
    if (plot && !sel_q && !erase_q && hit) touched_d = 1'b1;
  end

  // Overlap flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!resetn) touched_q <= 1'b0;
    else         touched_q <= touched_d;
  end

  assign bus.touched = touched_q;
`else
  logic bird_box_unused;
  assign bird_box_unused = ^{bird_x_q, bird_y_q, bird_valid_q};
  assign bus.touched     = 1'b0;
`endif

endmodule

// File: tb/tb_draw_engine.sv
// tb/tb_draw_engine.sv - scoreboard bench for draw_engine against a pixel-list reference model
module tb_draw_engine;

  localparam int BW = 4, BH = 4, WW = 8, GH = 32;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   pending;

  px_t exp_q[$];
  int  lat_q[$];
  int  start_q[$];
  int  touch_q[$];

  int  m_touched;
  int  m_bx, m_by, m_bv;

  draw_if bus ();

  draw_engine #(.BIRD_W(BW), .BIRD_H(BH), .WALL_W(WW), .GAP_H(GH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic flush();
    exp_q.delete();
    lat_q.delete();
    start_q.delete();
    touch_q.delete();
    pending = 0;
  endtask

  // Reference model: enumerate every visible pixel of the object, then update the overlap state
  task automatic issue(input int sel, input int er, input int x, input int y, input int gap);
    int w, h, base, col, hit;
    px_t p;
    w    = sel ? BW : WW;
    h    = sel ? BH : 120;
    base = sel ? y : 0;
    col  = er ? 3 : (sel ? 6 : 2);
    hit  = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        p.x = x + c;
        p.y = base + r;
        p.c = col;
        if (p.x < 160 && p.y < 120 && !(sel == 0 && r >= gap && r < gap + GH)) begin
          exp_q.push_back(p);
          if (m_bv != 0 && p.x >= m_bx && p.x < m_bx + BW && p.y >= m_by && p.y < m_by + BH)
            hit = 1;
        end
      end
    end
`ifdef DRAW_COLLIDE_EN
    if (sel == 0 && er == 0 && hit != 0) m_touched = 1;
`endif
    if (sel != 0 && er == 0) begin
      m_bx = x;
      m_by = y;
      m_bv = 1;
    end
    lat_q.push_back(w * h + 2);
    touch_q.push_back(m_touched);
    pending++;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.obj_sel = sel[0];
    bus.erase   = er[0];
    bus.obj_x   = x[7:0];
    bus.obj_y   = y[6:0];
    bus.gap_y   = gap[6:0];
    @(posedge clk);
    #1;
    start_q.push_back(cyc);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (pending > 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    if (pending > 0) begin
      chk("done_timeout", pending, 0);
      flush();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    flush();
    m_touched = 0;
    m_bv      = 0;
    @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_plot", bus.vga_plot, 0);
    chk("rst_vga_x", bus.vga_x, 0);
    chk("rst_vga_y", bus.vga_y, 0);
    chk("rst_colour", bus.vga_colour, 0);
    chk("rst_touched", bus.touched, 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: pop the scoreboard whenever the DUT plots or completes
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.vga_plot) begin
        if (exp_q.size() == 0) begin
          chk("plot_unexpected", 1, 0);
        end else begin
          px_t e;
          e = exp_q.pop_front();
          chk("plot_x", bus.vga_x, e.x);
          chk("plot_y", bus.vga_y, e.y);
          chk("plot_colour", bus.vga_colour, e.c);
        end
      end
      if (bus.done) begin
        chk("done_plot_low", bus.vga_plot, 0);
        chk("plots_left", exp_q.size(), 0);
        exp_q.delete();
        if (lat_q.size() == 0 || start_q.size() == 0 || touch_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          int l, s, t;
          l = lat_q.pop_front();
          s = start_q.pop_front();
          t = touch_q.pop_front();
          chk("latency", cyc - s + 1, l);
          chk("touched", bus.touched, t);
        end
        if (pending > 0) pending--;
      end
    end
  end

  initial begin
    cyc = 0;
    n_chk = 0;
    n_pass = 0;
    pending = 0;
    m_touched = 0;
    m_bx = 0;
    m_by = 0;
    m_bv = 0;
    resetn = 1'b0;
    bus.start = 1'b0;
    bus.obj_sel = 1'b0;
    bus.erase = 1'b0;
    bus.obj_x = '0;
    bus.obj_y = '0;
    bus.gap_y = '0;
    repeat (2) @(posedge clk);
    do_reset();

    issue(1, 0, 10, 20, 0);
    wait_idle(100);
    issue(0, 0, 50, 0, 40);
    wait_idle(1200);
    issue(0, 0, 156, 0, 100);
    wait_idle(1200);
    issue(1, 0, 52, 50, 0);
    wait_idle(100);
    issue(0, 0, 50, 0, 0);
    wait_idle(1200);
    issue(1, 1, 250, 118, 0);
    wait_idle(100);

    for (int i = 0; i < 8; i++) begin
      int sel, er;
      sel = int'($urandom_range(0, 1));
      er  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      issue(sel, er, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 127)));
      wait_idle(1200);
    end

    issue(1, 0, 30, 40, 0);
    repeat (4) @(negedge clk);
    bus.start   = 1'b1;
    bus.obj_sel = 1'b0;
    bus.obj_x   = 8'd90;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", bus.busy, 0);

    issue(0, 0, 20, 0, 60);
    repeat (100) @(negedge clk);
    bus.start   = 1'b1;
    bus.obj_sel = 1'b1;
    bus.erase   = 1'b1;
    bus.obj_x   = 8'd5;
    bus.obj_y   = 7'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_wall_busy", bus.busy, 1);
    do_reset();

    issue(1, 0, 158, 117, 0);
    wait_idle(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/draw_engine.md
DRAW_ENGINE -- requirements
Module: draw_engine

Interface
REQ-001 Parameter: BIRD_W, 4, bird sprite width in pixels.
REQ-002 Parameter: BIRD_H, 4, bird sprite height in pixels.
REQ-003 Parameter: WALL_W, 8, wall column width in pixels.
REQ-004 Parameter: GAP_H, 32, wall gap height in rows.
REQ-005 clk  in  1  system clock.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  one-cycle draw request from the game controller.
REQ-008 obj_sel  in  1  0 = wall, 1 = bird.
REQ-009 erase  in  1  1 = paint object in background colour.
REQ-010 obj_x  in  8  object left column, 0..255.
REQ-011 obj_y  in  7  bird top row; ignored for walls.
REQ-012 gap_y  in  7  wall gap top row; ignored for bird.
REQ-013 busy  out  1  high while a request is in progress.
REQ-014 done  out  1  one-cycle pulse at request completion.
REQ-015 vga_x  out  8; vga_y  out  7; vga_colour  out  3; vga_plot  out  1: pixel write port to the VGA adapter.
REQ-016 touched  out  1  sticky bird/wall overlap flag consumed by the game controller.

Function
REQ-017 FSM states: IDLE, LOAD, DRAW, FINISH.
REQ-018 In IDLE, start SHALL latch obj_sel, erase, obj_x, obj_y and gap_y and move to LOAD; start while busy SHALL be ignored.
REQ-019 LOAD SHALL clear the column/row counters and move to DRAW next cycle; busy is high from LOAD through FINISH.
REQ-020 DRAW SHALL visit one pixel per cycle in row-major order: bird BIRD_W x BIRD_H from (obj_x, obj_y); wall WALL_W x 120 from (obj_x, 0).
REQ-021 vga_x = latched x + column and vga_y = base row + row, each truncated to port width; vga_plot is asserted in the same cycle.
REQ-022 vga_plot SHALL be 0 for pixels with x > 159, y > 119, or (wall) row in [gap_y, gap_y+GAP_H-1]; the cycle is still consumed.
REQ-023 Colour: erase 3'b011; bird 3'b110; wall 3'b010.
REQ-024 After the last pixel, FSM SHALL enter FINISH for one cycle with done = 1 and vga_plot = 0, then return to IDLE.
REQ-025 Request latency from start to done: bird 1+1+16 = 18 cycles and wall 1+1+960 = 962 cycles at defaults.
REQ-026 A non-erase bird request SHALL store obj_x/obj_y as the current bird box.

Reset
REQ-027 When resetn = 0 at a clock edge, the FSM SHALL enter IDLE, including mid-request. It SHALL clear busy, done, vga_plot, vga_x, vga_y, vga_colour, touched, the counters and the bird box, and SHALL mark the bird box invalid.

Configuration
REQ-028 Macro: DRAW_COLLIDE_EN.
REQ-029 When defined: during a non-erase wall request, any plotted pixel inside a valid bird box SHALL set touched in the next cycle. touched SHALL stay at 1 until reset.
REQ-030 When undefined: touched SHALL be tied to 0 and no bird-box comparison logic is built.

Structure
REQ-031 Shared package draw_pkg SHALL hold the FSM state encoding, the colour constants, and the screen limits SCREEN_W = 160 and SCREEN_H = 120.
REQ-032 Sub-module rect_scan (column/row counter with last-pixel flag) is natural; all other logic resides in draw_engine.

Verification
REQ-033 Reset, then bird request at x=10, y=20 -> 16 plots covering (10..13, 20..23) in colour 110, and done at cycle 18.
REQ-034 Wall request at x=50 with gap_y=40 -> 960 cycles, 8x88 = 704 plots, no plot in rows 40..71, and colour 010.
REQ-035 Wall request at x=156 -> plots only in columns 156..159, with 960 cycles still consumed.
REQ-036 Bird request at x=52, y=50 followed by a wall request at x=50 with gap_y=0 (DRAW_COLLIDE_EN defined) -> touched rises during the wall request and stays at 1. With the macro undefined, touched stays at 0.
REQ-037 Assert start again during DRAW, then drop resetn mid-wall -> the second start is ignored, and after reset busy = 0, vga_plot = 0 and touched = 0.
